// File: rtl/fsm_parallel_ctrl.sv
// ----------------------------------------------------------------------------
// fsm_parallel_ctrl
//
// Sequencing controller for the N-lane parallel MAC array. A job has n_rows
// output rows, and each row needs k_len accumulation steps. The layer
// scheduler starts a job with a start/busy/done handshake. The MAC datapath
// receives a load strobe per row, an accumulate strobe per step, and
// step/row indices. COMPUTE advances only on cycles where in_valid is high.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset
//   start        in   job request, sampled only in IDLE
//   k_len        in   [KW-1:0] steps per row, sampled with start
//   n_rows       in   [RW-1:0] rows per job, sampled with start
//   in_valid     in   operands valid this cycle
//   abort        in   (FSM_PARALLEL_CTRL_ABORT_EN only) kill the running job
//   busy         out  high in every state except IDLE
//   load_enable  out  one-cycle pulse per row: clear accumulators, load weights
//   acc_enable   out  MAC accumulate strobe (COMPUTE and in_valid)
//   k_idx        out  [KI-1:0] current step index within the row
//   row_idx      out  [RI-1:0] current row index
//   row_done     out  one-cycle pulse after the last step of a row
//   done         out  one-cycle pulse at end of job
//
// Build option
//   FSM_PARALLEL_CTRL_ABORT_EN : adds the abort input. When abort is high in
//   any non-IDLE state, the controller returns to IDLE on the next cycle and
//   clears both indices. It also masks that cycle's strobes. Reset takes
//   priority over abort, and abort takes priority over start.
// ----------------------------------------------------------------------------
module fsm_parallel_ctrl #(
    parameter  int N        = 4,
    parameter  int MAX_K    = 16,
    parameter  int MAX_ROWS = 8,
    localparam int KW       = $clog2(MAX_K + 1),
    localparam int KI       = (MAX_K > 1) ? $clog2(MAX_K) : 1,
    localparam int RW       = $clog2(MAX_ROWS + 1),
    localparam int RI       = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic [RW-1:0] n_rows,
    input  logic          in_valid,
`ifdef FSM_PARALLEL_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          busy,
    output logic          load_enable,
    output logic          acc_enable,
    output logic [KI-1:0] k_idx,
    output logic [RI-1:0] row_idx,
    output logic          row_done,
    output logic          done
);

    // N has no effect on widths. It is checked here so that an
    // inconsistent lane count fails at elaboration and not in silicon.
    if (N < 1) begin : g_bad_lanes
        $error("fsm_parallel_ctrl: N must be at least 1");
    end
    if (MAX_K < 1 || MAX_ROWS < 1) begin : g_bad_bounds
        $error("fsm_parallel_ctrl: MAX_K and MAX_ROWS must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and configuration registers
    // ------------------------------------------------------------------------
    state_t        state_q,       state_d;
    logic [KW-1:0] k_cfg_q,       k_cfg_d;      // latched, clamped step count
    logic [RW-1:0] r_cfg_q,       r_cfg_d;      // latched, clamped row count
    logic [KI-1:0] k_idx_q,       k_idx_d;
    logic [RI-1:0] row_idx_q,     row_idx_d;

    // Registered Moore outputs. They are decoded from the next state so they
    // line up with the state they describe.
    logic          busy_q,        busy_d;
    logic          load_enable_q, load_enable_d;
    logic          row_done_q,    row_done_d;
    logic          done_q,        done_d;

    // ------------------------------------------------------------------------
    // Helper decodes
    // ------------------------------------------------------------------------
    logic          abort_act;     // abort is live (only outside IDLE)
    logic          zero_cfg;      // start request with nothing to do
    logic          last_k;        // current step is the last one of the row
    logic          last_row;      // current row is the last one of the job
    logic [KW-1:0] k_clamped;
    logic [RW-1:0] r_clamped;

`ifdef FSM_PARALLEL_CTRL_ABORT_EN
    assign abort_act = abort & (state_q != S_IDLE);
`else
    assign abort_act = 1'b0;
`endif

    assign zero_cfg  = (k_len == '0) || (n_rows == '0);
    assign k_clamped = (k_len  > KW'(MAX_K))    ? KW'(MAX_K)    : k_len;
    assign r_clamped = (n_rows > RW'(MAX_ROWS)) ? RW'(MAX_ROWS) : n_rows;

    // The latched bounds are never zero while busy, so subtracting one
    // cannot underflow on any path that uses these compares.
    assign last_k    = (KW'(k_idx_q)   == (k_cfg_q - KW'(1)));
    assign last_row  = (RW'(row_idx_q) == (r_cfg_q - RW'(1)));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every value computed here is first defaulted to hold its
        // current value. No path through the case can then leave a signal
        // unassigned, which would infer a latch.
        state_d   = state_q;
        k_cfg_d   = k_cfg_q;
        r_cfg_d   = r_cfg_q;
        k_idx_d   = k_idx_q;
        row_idx_d = row_idx_q;

        if (abort_act) begin
            state_d   = S_IDLE;
            k_idx_d   = '0;
            row_idx_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (zero_cfg) begin
                            // Nothing to compute. Go straight to done and
                            // skip any load, accumulate or row activity.
                            state_d = S_DONE;
                        end else begin
                            state_d   = S_LOAD;
                            k_cfg_d   = k_clamped;
                            r_cfg_d   = r_clamped;
                            k_idx_d   = '0;
                            row_idx_d = '0;
                        end
                    end
                end

                S_LOAD: begin
                    state_d = S_COMPUTE;
                end

                S_COMPUTE: begin
                    // Without operands, hold the state and the step index.
                    if (in_valid) begin
                        if (last_k) begin
                            k_idx_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            k_idx_d = k_idx_q + KI'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (last_row) begin
                        // row_idx keeps the final row through DONE.
                        state_d = S_DONE;
                    end else begin
                        row_idx_d = row_idx_q + RI'(1);
                        state_d   = S_LOAD;
                    end
                end

                S_DONE: begin
                    state_d   = S_IDLE;
                    row_idx_d = '0;
                end

                default: begin
                    state_d   = S_IDLE;
                    k_idx_d   = '0;
                    row_idx_d = '0;
                end
            endcase
        end

        busy_d        = (state_d != S_IDLE);
        load_enable_d = (state_d == S_LOAD);
        row_done_d    = (state_d == S_DRAIN);
        done_d        = (state_d == S_DONE);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from values sampled before the edge, whatever
    // order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            k_cfg_q       <= '0;
            r_cfg_q       <= '0;
            k_idx_q       <= '0;
            row_idx_q     <= '0;
            busy_q        <= 1'b0;
            load_enable_q <= 1'b0;
            row_done_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_cfg_q       <= k_cfg_d;
            r_cfg_q       <= r_cfg_d;
            k_idx_q       <= k_idx_d;
            row_idx_q     <= row_idx_d;
            busy_q        <= busy_d;
            load_enable_q <= load_enable_d;
            row_done_q    <= row_done_d;
            done_q        <= done_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // acc_enable is the only output that depends on an input in the same
    // cycle. It must follow in_valid directly so that stalled cycles are
    // not accumulated.
    assign acc_enable  = (state_q == S_COMPUTE) & in_valid & ~abort_act;
    assign busy        = busy_q;
    assign load_enable = load_enable_q & ~abort_act;
    assign row_done    = row_done_q    & ~abort_act;
    assign done        = done_q        & ~abort_act;
    assign k_idx       = k_idx_q;
    assign row_idx     = row_idx_q;

endmodule

// File: tb/tb_fsm_parallel_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fsm_parallel_ctrl
//
// Self-checking bench for fsm_parallel_ctrl. A table of jobs is applied one
// at a time. For each job, the expected strobe sequence (load per row,
// accumulate per step, row-done per row, then done) is pushed to a
// scoreboard queue, and every strobe the DUT emits pops and compares one
// entry. The expected done cycle, strobe counts and busy window are hand-
// derived constants in the table. Reset, mid-job reset and abort are
// covered by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_fsm_parallel_ctrl;

    localparam int N        = 4;
    localparam int MAX_K    = 16;
    localparam int MAX_ROWS = 8;
    localparam int KW       = $clog2(MAX_K + 1);
    localparam int KI       = (MAX_K > 1) ? $clog2(MAX_K) : 1;
    localparam int RW       = $clog2(MAX_ROWS + 1);
    localparam int RI       = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] k_len;
    logic [RW-1:0] n_rows;
    logic          in_valid;
`ifdef FSM_PARALLEL_CTRL_ABORT_EN
    logic          abort;
`endif
    logic          busy;
    logic          load_enable;
    logic          acc_enable;
    logic [KI-1:0] k_idx;
    logic [RI-1:0] row_idx;
    logic          row_done;
    logic          done;

    fsm_parallel_ctrl #(
        .N        (N),
        .MAX_K    (MAX_K),
        .MAX_ROWS (MAX_ROWS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .n_rows      (n_rows),
        .in_valid    (in_valid),
`ifdef FSM_PARALLEL_CTRL_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .load_enable (load_enable),
        .acc_enable  (acc_enable),
        .k_idx       (k_idx),
        .row_idx     (row_idx),
        .row_done    (row_done),
        .done        (done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {EV_LOAD, EV_ACC, EV_ROW, EV_DONE} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       row;
        int       k;
    } ev_t;

    ev_t sb[$];

    // Expected strobe sequence of one job, built from the job definition
    // (rows of steps), not from the controller's state machine.
    task automatic push_job(input int k_req, input int r_req);
        int ke;
        int re;
        ke = (k_req > MAX_K)    ? MAX_K    : k_req;
        re = (r_req > MAX_ROWS) ? MAX_ROWS : r_req;
        if (k_req == 0 || r_req == 0) begin
            sb.push_back('{kind: EV_DONE, row: 0, k: 0});
        end else begin
            for (int rr = 0; rr < re; rr++) begin
                sb.push_back('{kind: EV_LOAD, row: rr, k: 0});
                for (int kk = 0; kk < ke; kk++)
                    sb.push_back('{kind: EV_ACC, row: rr, k: kk});
                sb.push_back('{kind: EV_ROW, row: rr, k: 0});
            end
            sb.push_back('{kind: EV_DONE, row: re - 1, k: 0});
        end
    endtask

    task automatic expect_event(input ev_kind_t kind);
        ev_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe kind=%0d row_idx=%0d k_idx=%0d expected=none (t=%0t)",
                     kind, row_idx, k_idx, $time);
        end else begin
            e = sb.pop_front();
            check("ev_kind", kind,    e.kind);
            check("ev_row",  row_idx, e.row);
            check("ev_k",    k_idx,   e.k);
        end
    endtask

    // ------------------------------------------------------------------------
    // Job table
    // ------------------------------------------------------------------------
    typedef struct {
        int k_len;
        int n_rows;
        int stall_lo;     // in_valid low for cycles stall_lo..stall_hi
        int stall_hi;
        int restart;      // cycle to re-assert start while busy, -1 = none
        int hold_k;       // k_idx expected during the stall, -1 = none
        int exp_done;     // cycle of the done pulse (start at cycle 0)
        int exp_acc;
        int exp_load;
        int exp_row;
    } job_t;

    localparam int NJOBS = 9;
    job_t jobs[NJOBS];

    task automatic run_job(input job_t j);
        int n_acc  = 0;
        int n_load = 0;
        int n_row  = 0;
        int n_done = 0;
        int done_cyc = -1;
        push_job(j.k_len, j.n_rows);
        @(posedge clk); #1;
        for (int cyc = 0; cyc <= j.exp_done + 2; cyc++) begin
            start    = (cyc == 0) || (cyc == j.restart);
            k_len    = (cyc == j.restart) ? KW'(7) : KW'(j.k_len);
            n_rows   = (cyc == j.restart) ? RW'(7) : RW'(j.n_rows);
            in_valid = !(cyc >= j.stall_lo && cyc <= j.stall_hi);
            @(negedge clk);
            check("busy", busy, (cyc >= 1 && cyc <= j.exp_done));
            if (cyc == 0 || cyc > j.exp_done) begin
                check("idle_k_idx",   k_idx,   0);
                check("idle_row_idx", row_idx, 0);
            end
            if (cyc >= j.stall_lo && cyc <= j.stall_hi) begin
                check("stall_acc", acc_enable, 0);
                if (j.hold_k >= 0) check("stall_k_idx", k_idx, j.hold_k);
            end
            if (load_enable) begin n_load++; expect_event(EV_LOAD); end
            if (acc_enable)  begin n_acc++;  expect_event(EV_ACC);  end
            if (row_done)    begin n_row++;  expect_event(EV_ROW);  end
            if (done)        begin n_done++; done_cyc = cyc; expect_event(EV_DONE); end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_cycle",   done_cyc, j.exp_done);
        check("done_count",   n_done,   1);
        check("acc_count",    n_acc,    j.exp_acc);
        check("load_count",   n_load,   j.exp_load);
        check("row_count",    n_row,    j.exp_row);
        check("sb_leftover",  sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_all_idle(input string tag);
        check({tag, "_busy"},     busy,        0);
        check({tag, "_load"},     load_enable, 0);
        check({tag, "_acc"},      acc_enable,  0);
        check({tag, "_row_done"}, row_done,    0);
        check({tag, "_done"},     done,        0);
        check({tag, "_k_idx"},    k_idx,       0);
        check({tag, "_row_idx"},  row_idx,     0);
    endtask

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        // k, r, stall_lo, stall_hi, restart, hold_k, done, acc, load, row
        jobs[0] = '{3,  2, -1, -1, -1, -1, 11,   6, 2, 2};  // basic
        jobs[1] = '{4,  1,  3,  5, -1,  1, 10,   4, 1, 1};  // 3-cycle stall
        jobs[2] = '{0,  5, -1, -1, -1, -1,  1,   0, 0, 0};  // zero k
        jobs[3] = '{3,  0, -1, -1, -1, -1,  1,   0, 0, 0};  // zero rows
        jobs[4] = '{31, 1, -1, -1, -1, -1, 19,  16, 1, 1};  // k clamp
        jobs[5] = '{5, 15, -1, -1, -1, -1, 57,  40, 8, 8};  // row clamp
        jobs[6] = '{1,  1, -1, -1, -1, -1,  4,   1, 1, 1};  // minimum job
        jobs[7] = '{16, 8, -1, -1, -1, -1, 145, 128, 8, 8}; // full size
        jobs[8] = '{2,  3, -1, -1,  4, -1, 13,   6, 3, 3};  // start while busy

        rst      = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        n_rows   = '0;
        in_valid = 1'b1;
`ifdef FSM_PARALLEL_CTRL_ABORT_EN
        abort    = 1'b0;
`endif

        // Reset for two cycles, then ten idle cycles with operands valid
        @(posedge clk); #1;
        @(negedge clk);
        check_all_idle("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_all_idle("reset_idle");
        end

        // Table-driven jobs
        for (int i = 0; i < NJOBS; i++) run_job(jobs[i]);

        // Reset mid-job: k_len=8, n_rows=2, rst during cycle 4
        @(posedge clk); #1;
        start  = 1'b1;
        k_len  = KW'(8);
        n_rows = RW'(2);
        in_valid = 1'b1;
        for (int cyc = 0; cyc <= 6; cyc++) begin
            rst = (cyc == 4);
            @(negedge clk);
            if (cyc == 1) check("midrst_load_c1", load_enable, 1);
            if (cyc == 4) begin
                check("midrst_k_idx_c4", k_idx, 2);
                check("midrst_acc_c4",   acc_enable, 1);
                check("midrst_busy_c4",  busy, 1);
            end
            if (cyc >= 5) check_all_idle("midrst_after");
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b0;
        // Fresh job (cycle 7 relative to the killed start)
        begin
            job_t j;
            j = '{8, 2, -1, -1, -1, -1, 21, 16, 2, 2};
            run_job(j);
        end

`ifdef FSM_PARALLEL_CTRL_ABORT_EN
        // Abort during cycle 3 of a k_len=3, n_rows=2 job
        @(posedge clk); #1;
        start  = 1'b1;
        k_len  = KW'(3);
        n_rows = RW'(2);
        for (int cyc = 0; cyc <= 15; cyc++) begin
            abort = (cyc == 3);
            @(negedge clk);
            if (cyc == 3) begin
                check("abort_acc_c3",  acc_enable, 0);
                check("abort_busy_c3", busy, 1);
            end
            if (cyc >= 4) check_all_idle("after_abort");
            @(posedge clk); #1;
            start = 1'b0;
        end
        abort = 1'b0;

        // Abort in IDLE is ignored: start with abort high is accepted
        start  = 1'b1;
        abort  = 1'b1;
        k_len  = KW'(2);
        n_rows = RW'(1);
        @(negedge clk);
        check("abort_idle_busy_c0", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                check("abort_idle_busy_c1", busy, 1);
                check("abort_idle_load_c1", load_enable, 1);
            end
            check("abort_idle_done", done, (cyc == 5));
            @(posedge clk); #1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
